// File: rtl/data_mem_controller.sv
// data_mem_controller
//   Shares a single data-memory port between NUM_CONSUMERS load-store units.
//   Arbitration is round-robin, and only one memory transaction is in flight
//   at a time. Both the LSU side and the memory side use valid/ready.
//
// Optional feature (macro DATA_MEM_CTRL_PERF_CNT_EN):
//   Adds read_count/write_count. These are saturating 16-bit counters of
//   completed consumer reads and writes.
//
// Ports:
//   clk, reset (async, active-low)
//   consumer_read_valid/address   -> consumer_read_ready/data (flattened per LSU)
//   consumer_write_valid/address/data -> consumer_write_ready
//   mem_read_valid/address  <- mem_read_ready/data
//   mem_write_valid/address/data <- mem_write_ready
//   read_count/write_count (only with DATA_MEM_CTRL_PERF_CNT_EN)
//
// state      | meaning
// IDLE       | arbitrating; nothing outstanding
// READ_WAIT  | memory read issued, waiting for mem_read_ready
// WRITE_WAIT | memory write issued, waiting for mem_write_ready
// RELEASE    | ready pulse issued, waiting for granted LSU to drop its valids
module data_mem_controller #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
  output logic                                 mem_read_valid,
  output logic [ADDR_BITS-1:0]                 mem_read_address,
  input  logic                                 mem_read_ready,
  input  logic [DATA_BITS-1:0]                 mem_read_data,
  output logic                                 mem_write_valid,
  output logic [ADDR_BITS-1:0]                 mem_write_address,
  output logic [DATA_BITS-1:0]                 mem_write_data,
  input  logic                                 mem_write_ready
`ifdef DATA_MEM_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]                          read_count,
  output logic [15:0]                          write_count
`endif
);

  localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RELEASE    = 2'd3
  } state_t;

  state_t                             state_q, state_d;
  logic [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]                   grant_id_q, grant_id_d;
  logic                               mem_read_valid_q, mem_read_valid_d;
  logic [ADDR_BITS-1:0]               mem_read_address_q, mem_read_address_d;
  logic                               mem_write_valid_q, mem_write_valid_d;
  logic [ADDR_BITS-1:0]               mem_write_address_q, mem_write_address_d;
  logic [DATA_BITS-1:0]               mem_write_data_q, mem_write_data_d;
  logic [NUM_CONSUMERS-1:0]           read_ready_q, read_ready_d;
  logic [NUM_CONSUMERS-1:0]           write_ready_q, write_ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] read_data_q, read_data_d;

  logic                               found;
  logic [PTR_W-1:0]                   win_id;
  logic                               read_done;
  logic                               write_done;

  // Round-robin scan starting at rr_ptr; the first LSU with any valid wins.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    win_id = rr_ptr_q;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_CONSUMERS;
      if (!found && (consumer_read_valid[idx] || consumer_write_valid[idx])) begin
        found  = 1'b1;
        win_id = PTR_W'(idx);
      end
    end
  end

  assign read_done  = (state_q == READ_WAIT) && mem_read_ready;
  assign write_done = (state_q == WRITE_WAIT) && mem_write_ready;

  always_comb begin
    state_d             = state_q;
    rr_ptr_d            = rr_ptr_q;
    grant_id_d          = grant_id_q;
    mem_read_valid_d    = mem_read_valid_q;
    mem_read_address_d  = mem_read_address_q;
    mem_write_valid_d   = mem_write_valid_q;
    mem_write_address_d = mem_write_address_q;
    mem_write_data_d    = mem_write_data_q;
    read_data_d         = read_data_q;
    // Ready outputs are only ever set for the single completion edge.
    read_ready_d        = '0;
    write_ready_d       = '0;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_id_d = win_id;
          // Read takes priority when the winner requests both.
          if (consumer_read_valid[win_id]) begin
            mem_read_valid_d   = 1'b1;
            mem_read_address_d = consumer_read_address[win_id*ADDR_BITS +: ADDR_BITS];
            state_d            = READ_WAIT;
          end else begin
            mem_write_valid_d   = 1'b1;
            mem_write_address_d = consumer_write_address[win_id*ADDR_BITS +: ADDR_BITS];
            mem_write_data_d    = consumer_write_data[win_id*DATA_BITS +: DATA_BITS];
            state_d             = WRITE_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          read_data_d[grant_id_q*DATA_BITS +: DATA_BITS] = mem_read_data;
          read_ready_d[grant_id_q] = 1'b1;
          mem_read_valid_d         = 1'b0;
          state_d                  = RELEASE;
        end
      end
      WRITE_WAIT: begin
        if (mem_write_ready) begin
          write_ready_d[grant_id_q] = 1'b1;
          mem_write_valid_d         = 1'b0;
          state_d                   = RELEASE;
        end
      end
      RELEASE: begin
        // Waiting for the LSU to drop its valid keeps the same request from
        // being served twice.
        if (!consumer_read_valid[grant_id_q] && !consumer_write_valid[grant_id_q]) begin
          state_d  = IDLE;
          rr_ptr_d = PTR_W'((int'(grant_id_q) + 1) % NUM_CONSUMERS);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DATA_MEM_CTRL_PERF_CNT_EN
  logic [15:0] read_count_q, read_count_d;
  logic [15:0] write_count_q, write_count_d;

  always_comb begin
    read_count_d  = read_count_q;
    write_count_d = write_count_q;
    if (read_done && (read_count_q != 16'hFFFF))
      read_count_d = read_count_q + 16'd1;
    if (write_done && (write_count_q != 16'hFFFF))
      write_count_d = write_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_count_q  <= '0;
      write_count_q <= '0;
    end else begin
      read_count_q  <= read_count_d;
      write_count_q <= write_count_d;
    end
  end

  assign read_count  = read_count_q;
  assign write_count = write_count_q;
`else
  logic unused_done;
  assign unused_done = read_done ^ write_done;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q             <= IDLE;
      rr_ptr_q            <= '0;
      grant_id_q          <= '0;
      mem_read_valid_q    <= 1'b0;
      mem_read_address_q  <= '0;
      mem_write_valid_q   <= 1'b0;
      mem_write_address_q <= '0;
      mem_write_data_q    <= '0;
      read_ready_q        <= '0;
      write_ready_q       <= '0;
      read_data_q         <= '0;
    end else begin
      state_q             <= state_d;
      rr_ptr_q            <= rr_ptr_d;
      grant_id_q          <= grant_id_d;
      mem_read_valid_q    <= mem_read_valid_d;
      mem_read_address_q  <= mem_read_address_d;
      mem_write_valid_q   <= mem_write_valid_d;
      mem_write_address_q <= mem_write_address_d;
      mem_write_data_q    <= mem_write_data_d;
      read_ready_q        <= read_ready_d;
      write_ready_q       <= write_ready_d;
      read_data_q         <= read_data_d;
    end
  end

  assign consumer_read_ready  = read_ready_q;
  assign consumer_read_data   = read_data_q;
  assign consumer_write_ready = write_ready_q;
  assign mem_read_valid       = mem_read_valid_q;
  assign mem_read_address     = mem_read_address_q;
  assign mem_write_valid      = mem_write_valid_q;
  assign mem_write_address    = mem_write_address_q;
  assign mem_write_data       = mem_write_data_q;

endmodule

// File: tb/tb_data_mem_controller.sv
// tb_data_mem_controller
//   Directed bench for data_mem_controller (4 LSUs, 8-bit address/data).
//   Inputs are driven and outputs sampled on the falling clock edge.
//   With DATA_MEM_CTRL_PERF_CNT_EN defined, the bench also checks the counters.
module tb_data_mem_controller;

  localparam int N = 4;
  localparam int A = 8;
  localparam int D = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   consumer_read_valid;
  logic [N*A-1:0] consumer_read_address;
  logic [N-1:0]   consumer_read_ready;
  logic [N*D-1:0] consumer_read_data;
  logic [N-1:0]   consumer_write_valid;
  logic [N*A-1:0] consumer_write_address;
  logic [N*D-1:0] consumer_write_data;
  logic [N-1:0]   consumer_write_ready;
  logic           mem_read_valid;
  logic [A-1:0]   mem_read_address;
  logic           mem_read_ready;
  logic [D-1:0]   mem_read_data;
  logic           mem_write_valid;
  logic [A-1:0]   mem_write_address;
  logic [D-1:0]   mem_write_data;
  logic           mem_write_ready;
`ifdef DATA_MEM_CTRL_PERF_CNT_EN
  logic [15:0]    read_count;
  logic [15:0]    write_count;
`endif

  // Memory read data either comes from a simple address-derived model or is
  // driven by hand.
  logic           use_model;
  logic [D-1:0]   manual_rdata;
  assign mem_read_data = use_model ? (mem_read_address ^ 8'h5A) : manual_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_mem_controller #(.NUM_CONSUMERS(N), .ADDR_BITS(A), .DATA_BITS(D)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
`ifdef DATA_MEM_CTRL_PERF_CNT_EN
    ,
    .read_count             (read_count),
    .write_count            (write_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [D-1:0] rd_slice(input int i);
    return consumer_read_data[i*D +: D];
  endfunction

  // All four LSUs read together and hold their valids until served. Service
  // must come out in order 0,1,2,3, one consumer per ready pulse.
  task automatic run_round(input int rnd);
    int order[$];
    int cyc;
    logic [A-1:0] addr [N];
    for (int i = 0; i < N; i++) begin
      addr[i] = 8'(8'h40 + i + rnd * 8);
      consumer_read_address[i*A +: A] = addr[i];
    end
    consumer_read_valid = '1;
    cyc = 0;
    while (order.size() < N && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (consumer_read_ready != '0) begin
        chk("rr_onehot", 32'($countones(consumer_read_ready)), 32'd1);
        for (int i = 0; i < N; i++) begin
          if (consumer_read_ready[i]) begin
            order.push_back(i);
            chk("rr_data", 32'(rd_slice(i)), 32'(addr[i] ^ 8'h5A));
            consumer_read_valid[i] = 1'b0;
          end
        end
      end
    end
    chk("rr_served", 32'(order.size()), N);
    for (int k = 0; k < order.size(); k++)
      chk("rr_order", 32'(order[k]), 32'(k));
    consumer_read_valid = '0;
    @(negedge clk);
  endtask

  initial begin
    reset                  = 1'b0;
    consumer_read_valid    = '0;
    consumer_read_address  = '0;
    consumer_write_valid   = '0;
    consumer_write_address = '0;
    consumer_write_data    = '0;
    mem_read_ready         = 1'b0;
    mem_write_ready        = 1'b0;
    use_model              = 1'b1;
    manual_rdata           = '0;

    // Reset state
    #1;
    chk("rst_mem_read_valid", 32'(mem_read_valid), 32'd0);
    chk("rst_mem_write_valid", 32'(mem_write_valid), 32'd0);
    chk("rst_read_ready", 32'(consumer_read_ready), 32'd0);
    chk("rst_write_ready", 32'(consumer_write_ready), 32'd0);
    chk("rst_read_data", consumer_read_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Fairness: two rounds of zero-wait memory, mem_read_ready held high
    mem_read_ready = 1'b1;
    run_round(0);
    run_round(1);

    // Sticky valid: consumer 0 holds its valid for 3 cycles after the pulse
    consumer_read_address[0*A +: A] = 8'h05;
    consumer_read_valid[0] = 1'b1;
    @(negedge clk);
    chk("sticky_grant", 32'(mem_read_valid), 32'd1);
    @(negedge clk);
    chk("sticky_ready", 32'(consumer_read_ready), 32'b0001);
    chk("sticky_data", 32'(rd_slice(0)), 32'h5F);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("sticky_no_reissue", 32'(mem_read_valid), 32'd0);
      chk("sticky_ready_clear", 32'(consumer_read_ready), 32'd0);
    end
    consumer_read_valid[0] = 1'b0;
    @(negedge clk);
    chk("sticky_idle", 32'(mem_read_valid), 32'd0);
    @(negedge clk);
    chk("sticky_idle2", 32'(mem_read_valid), 32'd0);

    // Single read: consumer 1 at 0x3C, memory answers 0xA5 after 2 cycles
    use_model      = 1'b0;
    mem_read_ready = 1'b0;
    consumer_read_address[1*A +: A] = 8'h3C;
    consumer_read_valid[1] = 1'b1;
    @(negedge clk);
    chk("rd_valid", 32'(mem_read_valid), 32'd1);
    chk("rd_addr", 32'(mem_read_address), 32'h3C);
    @(negedge clk);
    chk("rd_valid_held", 32'(mem_read_valid), 32'd1);
    chk("rd_addr_held", 32'(mem_read_address), 32'h3C);
    chk("rd_no_early_ready", 32'(consumer_read_ready), 32'd0);
    mem_read_ready = 1'b1;
    manual_rdata   = 8'hA5;
    @(negedge clk);
    chk("rd_ready", 32'(consumer_read_ready), 32'b0010);
    chk("rd_data", 32'(rd_slice(1)), 32'hA5);
    chk("rd_valid_drop", 32'(mem_read_valid), 32'd0);
    mem_read_ready = 1'b0;
    consumer_read_valid[1] = 1'b0;
    @(negedge clk);
    chk("rd_pulse_1cyc", 32'(consumer_read_ready), 32'd0);
    chk("rd_data_persist", 32'(rd_slice(1)), 32'hA5);
    chk("rd_other_persist", 32'(rd_slice(0)), 32'h5F);

    // rr_ptr is now 2: with consumers 0 and 2 requesting, 2 must win
    consumer_read_address[0*A +: A] = 8'h0A;
    consumer_read_address[2*A +: A] = 8'h22;
    consumer_read_valid[0] = 1'b1;
    consumer_read_valid[2] = 1'b1;
    @(negedge clk);
    chk("rrptr_winner_addr", 32'(mem_read_address), 32'h22);
    mem_read_ready = 1'b1;
    manual_rdata   = 8'h33;
    @(negedge clk);
    chk("rrptr_ready", 32'(consumer_read_ready), 32'b0100);
    chk("rrptr_data", 32'(rd_slice(2)), 32'h33);
    consumer_read_valid[2] = 1'b0;
    mem_read_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("c0_after_addr", 32'(mem_read_address), 32'h0A);
    chk("c0_after_valid", 32'(mem_read_valid), 32'd1);
    mem_read_ready = 1'b1;
    manual_rdata   = 8'h44;
    @(negedge clk);
    chk("c0_after_ready", 32'(consumer_read_ready), 32'b0001);
    chk("c0_after_data", 32'(rd_slice(0)), 32'h44);
    consumer_read_valid[0] = 1'b0;
    mem_read_ready = 1'b0;
    @(negedge clk);

    // Single write: consumer 2, 0x10 <- 0x77, memory waits 2 cycles
    consumer_write_address[2*A +: A] = 8'h10;
    consumer_write_data[2*D +: D]    = 8'h77;
    consumer_write_valid[2] = 1'b1;
    @(negedge clk);
    chk("wr_valid", 32'(mem_write_valid), 32'd1);
    chk("wr_addr", 32'(mem_write_address), 32'h10);
    chk("wr_data", 32'(mem_write_data), 32'h77);
    @(negedge clk);
    chk("wr_valid_held", 32'(mem_write_valid), 32'd1);
    chk("wr_addr_held", 32'(mem_write_address), 32'h10);
    chk("wr_data_held", 32'(mem_write_data), 32'h77);
    chk("wr_no_early_ready", 32'(consumer_write_ready), 32'd0);
    mem_write_ready = 1'b1;
    @(negedge clk);
    chk("wr_ready", 32'(consumer_write_ready), 32'b0100);
    chk("wr_valid_drop", 32'(mem_write_valid), 32'd0);
    chk("wr_no_read_ready", 32'(consumer_read_ready), 32'd0);
    consumer_write_valid[2] = 1'b0;
    mem_write_ready = 1'b0;
    @(negedge clk);
    chk("wr_pulse_1cyc", 32'(consumer_write_ready), 32'd0);

`ifdef DATA_MEM_CTRL_PERF_CNT_EN
    chk("perf_reads", 32'(read_count), 32'd12);
    chk("perf_writes", 32'(write_count), 32'd1);
`endif

    // Reset during READ_WAIT (rr_ptr is 3 at this point)
    consumer_read_address[3*A +: A] = 8'h99;
    consumer_read_valid[3] = 1'b1;
    @(negedge clk);
    chk("rstmid_grant", 32'(mem_read_valid), 32'd1);
    chk("rstmid_addr", 32'(mem_read_address), 32'h99);
    #2;
    reset = 1'b0;
    #1;
    chk("rstmid_async_valid", 32'(mem_read_valid), 32'd0);
    chk("rstmid_no_ready", 32'(consumer_read_ready), 32'd0);
`ifdef DATA_MEM_CTRL_PERF_CNT_EN
    chk("perf_rst_reads", 32'(read_count), 32'd0);
    chk("perf_rst_writes", 32'(write_count), 32'd0);
`endif
    consumer_read_valid[3] = 1'b0;
    @(negedge clk);
    chk("rstmid_data_clear", consumer_read_data, 32'd0);
    chk("rstmid_ready_clear", 32'(consumer_read_ready), 32'd0);
    reset = 1'b1;
    consumer_read_address[0*A +: A] = 8'h01;
    consumer_read_valid[0] = 1'b1;
    consumer_read_valid[3] = 1'b1;
    @(negedge clk);
    chk("rstmid_c0_first_valid", 32'(mem_read_valid), 32'd1);
    chk("rstmid_c0_first_addr", 32'(mem_read_address), 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
